// File: rtl/ps2_mouse_init_ctrl.sv
// rtl/ps2_mouse_init_ctrl.sv - PS/2 mouse init sequencer and 3-byte stream packet framer
module ps2_mouse_init_ctrl #(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int PKT_GAP_CYCLES = 1_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       reinit_i,
    input  logic       tx_idle_i,
    input  logic       tx_done_tick_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_tick_i,
    output logic       wr_ps2_o,
    output logic [7:0] tx_data_o,
    output logic [8:0] xm_o,
    output logic [8:0] ym_o,
    output logic [2:0] btnm_o,
    output logic       m_done_tick_o,
    output logic       init_done_o,
    output logic       init_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(PKT_GAP_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [3:0] {
        S_SEND_RST     = 4'd0,
        S_WAIT_TX_RST  = 4'd1,
        S_WAIT_ACK_RST = 4'd2,
        S_WAIT_BAT     = 4'd3,
        S_WAIT_ID      = 4'd4,
        S_SEND_EN      = 4'd5,
        S_WAIT_TX_EN   = 4'd6,
        S_WAIT_ACK_EN  = 4'd7,
        S_STREAM       = 4'd8,
        S_ERROR        = 4'd9
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          fail;
    logic          tmo_hit;
    logic          timed;

    logic          wr_q, wr_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic [1:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic [8:0]    xm_q, xm_d;
    logic [8:0]    ym_q, ym_d;
    logic [2:0]    btn_q, btn_d;
    logic          tick_q, tick_d;

    // Only the init handshake states are supervised by the timeout counter
    assign timed   = (state_q != S_STREAM) && (state_q != S_ERROR);
    assign tmo_hit = timed && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // State register plus init supervision counters
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_SEND_RST;
            tmo_cnt_q <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            retry_q   <= retry_d;
        end
    end

    // Next-state logic: expected events advance, wrong bytes or timeouts count as a failed attempt
    always_comb begin
        state_d = state_q;
        fail    = 1'b0;
        case (state_q)
            S_SEND_RST: begin
                if (tx_idle_i)    state_d = S_WAIT_TX_RST;
                else if (tmo_hit) fail = 1'b1;
            end
            S_WAIT_TX_RST: begin
                if (tx_done_tick_i) state_d = S_WAIT_ACK_RST;
                else if (tmo_hit)   fail = 1'b1;
            end
            S_WAIT_ACK_RST: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RSP_ACK) state_d = S_WAIT_BAT;
                    else                      fail = 1'b1;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_BAT: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RSP_BAT_OK) state_d = S_WAIT_ID;
                    else                         fail = 1'b1;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_ID: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RSP_ID) state_d = S_SEND_EN;
                    else                     fail = 1'b1;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_SEND_EN: begin
                if (tx_idle_i)    state_d = S_WAIT_TX_EN;
                else if (tmo_hit) fail = 1'b1;
            end
            S_WAIT_TX_EN: begin
                if (tx_done_tick_i) state_d = S_WAIT_ACK_EN;
                else if (tmo_hit)   fail = 1'b1;
            end
            S_WAIT_ACK_EN: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RSP_ACK) state_d = S_STREAM;
                    else                      fail = 1'b1;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_STREAM: state_d = S_STREAM;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_SEND_RST;
        endcase

        retry_d = retry_q;
        if (fail) begin
            retry_d = retry_q + RW'(1);
            state_d = (retry_d == RW'(MAX_RETRIES)) ? S_ERROR : S_SEND_RST;
        end
        if (state_d == S_STREAM && state_q != S_STREAM) begin
            retry_d = '0;
        end
        if (reinit_i) begin
            state_d = S_SEND_RST;
            retry_d = '0;
        end

        // A failure that re-enters SEND_RST from SEND_RST is not a state change, so clear on fail too
        if (!timed || fail || reinit_i || state_d != state_q) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    // Output logic: command strobe and byte for the SEND states, status flags
    always_comb begin
        wr_d        = 1'b0;
        tx_data_d   = tx_data_q;
        init_done_o = (state_q == S_STREAM);
        init_err_o  = (state_q == S_ERROR);
        if (!reinit_i) begin
            if (state_q == S_SEND_RST && tx_idle_i) begin
                wr_d      = 1'b1;
                tx_data_d = CMD_RESET;
            end else if (state_q == S_SEND_EN && tx_idle_i) begin
                wr_d      = 1'b1;
                tx_data_d = CMD_ENABLE;
            end
        end
    end

    // Registered TX strobe; the byte stays on tx_data_o after the strobe
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_q      <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            wr_q      <= wr_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Stream framing: sync on bit3 of the first byte, drop partial packets after a long gap
    always_comb begin
        idx_d  = idx_q;
        gap_d  = gap_q;
        b0_d   = b0_q;
        b1_d   = b1_q;
        xm_d   = xm_q;
        ym_d   = ym_q;
        btn_d  = btn_q;
        tick_d = 1'b0;
        if (reinit_i || state_q != S_STREAM) begin
            idx_d = 2'd0;
            gap_d = '0;
        end else if (rx_done_tick_i) begin
            gap_d = '0;
            case (idx_q)
                2'd0: begin
                    if (rx_data_i[3]) begin
                        b0_d  = rx_data_i;
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    b1_d  = rx_data_i;
                    idx_d = 2'd2;
                end
                default: begin
                    xm_d   = b0_q[6] ? 9'd0 : {b0_q[4], b1_q};
                    ym_d   = b0_q[7] ? 9'd0 : {b0_q[5], rx_data_i};
                    btn_d  = b0_q[2:0];
                    tick_d = 1'b1;
                    idx_d  = 2'd0;
                end
            endcase
        end else if (idx_q != 2'd0) begin
            if (gap_q == GW'(PKT_GAP_CYCLES - 1)) begin
                idx_d = 2'd0;
                gap_d = '0;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
    end

    // Packet assembly registers; movement outputs clear only on reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            idx_q  <= 2'd0;
            gap_q  <= '0;
            b0_q   <= 8'h00;
            b1_q   <= 8'h00;
            xm_q   <= 9'd0;
            ym_q   <= 9'd0;
            btn_q  <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            gap_q  <= gap_d;
            b0_q   <= b0_d;
            b1_q   <= b1_d;
            xm_q   <= xm_d;
            ym_q   <= ym_d;
            btn_q  <= btn_d;
            tick_q <= tick_d;
        end
    end

    assign wr_ps2_o      = wr_q;
    assign tx_data_o     = tx_data_q;
    assign xm_o          = xm_q;
    assign ym_o          = ym_q;
    assign btnm_o        = btn_q;
    assign m_done_tick_o = tick_q;

endmodule
